// File: rtl/bram_wrapper_arbiter_pkg.sv
// Shared types and helpers for the bram_wrapper arbiter.
//   state_t   : arbiter FSM state, also exported on the top-level debug port
//   idx_width : index width for a count of items, never less than one bit
package bram_wrapper_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bram_wrapper_arbiter_if.sv
// Requester and bram_wrapper bus of the arbiter.
//   req_*  : per-requester request vectors (packed, requester 0 in the LSBs)
//   resp_* : shared completion bus, resp_valid_out is one-hot by requester
//   wr_*   : connection to bram_wrapper addr_in/data_in/read_enable/
//            write_enable/data_out/finished_out
// Handshake: a requester raises req_valid_in[r] with we/addr/data and holds
// all of them stable until it sees req_ready_out[r] high for one cycle; that
// pulse is the accept, after which valid may drop or present a new request.
// Exactly one resp_valid_out pulse follows every accept unless reset
// intervenes; resp_error_out is only meaningful during that pulse.
// Modports: slave = arbiter, master = requesters plus wrapper environment.
interface bram_wrapper_arbiter_if #(
  parameter int ADDR_SIZE = 5,
  parameter int WIDTH     = 256,
  parameter int NUM_REQ   = 2
);
  logic [NUM_REQ-1:0]           req_valid_in;
  logic [NUM_REQ-1:0]           req_we_in;
  logic [NUM_REQ*ADDR_SIZE-1:0] req_addr_in;
  logic [NUM_REQ*WIDTH-1:0]     req_data_in;
  logic [NUM_REQ-1:0]           req_ready_out;
  logic [NUM_REQ-1:0]           resp_valid_out;
  logic [WIDTH-1:0]             resp_data_out;
  logic                         resp_error_out;
  logic [ADDR_SIZE-1:0]         wr_addr_out;
  logic [WIDTH-1:0]             wr_data_out;
  logic                         wr_read_en_out;
  logic                         wr_write_en_out;
  logic [WIDTH-1:0]             wr_data_in;
  logic                         wr_finished_in;

  modport slave (
    input  req_valid_in, req_we_in, req_addr_in, req_data_in,
    input  wr_data_in, wr_finished_in,
    output req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
    output wr_addr_out, wr_data_out, wr_read_en_out, wr_write_en_out
  );

  modport master (
    output req_valid_in, req_we_in, req_addr_in, req_data_in,
    output wr_data_in, wr_finished_in,
    input  req_ready_out, resp_valid_out, resp_data_out, resp_error_out,
    input  wr_addr_out, wr_data_out, wr_read_en_out, wr_write_en_out
  );
endinterface

// File: rtl/bram_wrapper_arbiter_rr_priority_picker.sv
// Combinational round-robin picker.
//   valid : request vector, one bit per requester
//   last  : index of the most recently served requester
//   any   : at least one request is pending
//   grant : first pending index strictly after last, wrapping modulo NUM_REQ
module rr_priority_picker #(
  parameter int NUM_REQ = 2,
  parameter int GW      = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GW-1:0]      last,
  output logic               any,
  output logic [GW-1:0]      grant
);

  function automatic int wrap_idx(input int v);
    return (v >= NUM_REQ) ? v - NUM_REQ : v;
  endfunction

  // Walk from the farthest candidate back to the nearest so the nearest
  // pending requester after last is the final (winning) assignment.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (valid[GW'(wrap_idx(int'(last) + i))]) begin
        any   = 1'b1;
        grant = GW'(wrap_idx(int'(last) + i));
      end
    end
  end

endmodule

// File: rtl/bram_wrapper_arbiter.sv
// Shares one bram_wrapper between NUM_REQ requesters.
// One transaction in flight: accept (round-robin), pulse read/write enable
// for one cycle, wait for finished (bounded by a watchdog), then return the
// read data or a write ack to the requester that was granted.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   bus              : requester + wrapper bus (slave side)
//   timeout_out      : sticky, set when the watchdog aborted a transaction
//   dbg_state        : current FSM state
// Parameters: ADDRS words, WIDTH bits per word, NUM_REQ requesters,
// TIMEOUT maximum WAIT cycles.
module bram_wrapper_arbiter
  import bram_wrapper_arbiter_pkg::*;
#(
  parameter int ADDRS   = 24,
  parameter int WIDTH   = 256,
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  bram_wrapper_arbiter_if.slave   bus,
  output logic                    timeout_out,
  output state_t                  dbg_state
);

  localparam int ADDR_SIZE = idx_width(ADDRS);
  localparam int GW        = idx_width(NUM_REQ);
  localparam int WD_W      = idx_width(TIMEOUT);

  // One extra bit so an ADDRS that is a power of two still fits.
  localparam logic [ADDR_SIZE:0] ADDRS_LIM = (ADDR_SIZE + 1)'(ADDRS);
  localparam logic [WD_W-1:0]    WD_LAST   = WD_W'(TIMEOUT - 1);
  localparam logic [GW-1:0]      GRANT_RST = GW'(NUM_REQ - 1);

  typedef struct packed {
    logic                 we;
    logic [ADDR_SIZE-1:0] addr;
    logic [WIDTH-1:0]     data;
    logic [GW-1:0]        grant;
  } op_t;

  state_t               state;
  op_t                  op;
  logic [WD_W-1:0]      wdog;
  logic [GW-1:0]        last_grant;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ-1:0]   resp_valid;
  logic [WIDTH-1:0]     resp_data;
  logic                 resp_error;
  logic                 timeout_flag;
  logic                 rd_en;
  logic                 wr_en;

  logic                 pick_any;
  logic [GW-1:0]        pick_grant;
  logic [ADDR_SIZE-1:0] pick_addr;
  logic [WIDTH-1:0]     pick_data;
  logic                 pick_addr_ok;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .GW      (GW)
  ) u_picker (
    .valid (bus.req_valid_in),
    .last  (last_grant),
    .any   (pick_any),
    .grant (pick_grant)
  );

  assign pick_addr    = bus.req_addr_in[int'(pick_grant)*ADDR_SIZE +: ADDR_SIZE];
  assign pick_data    = bus.req_data_in[int'(pick_grant)*WIDTH +: WIDTH];
  assign pick_addr_ok = ({1'b0, pick_addr} < ADDRS_LIM);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= S_IDLE;
      op           <= '0;
      wdog         <= '0;
      last_grant   <= GRANT_RST;
      req_ready    <= '0;
      resp_valid   <= '0;
      resp_data    <= '0;
      resp_error   <= 1'b0;
      timeout_flag <= 1'b0;
      rd_en        <= 1'b0;
      wr_en        <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle; states raise them for one.
      req_ready  <= '0;
      resp_valid <= '0;
      resp_error <= 1'b0;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;

      case (state)
        S_IDLE: begin
          if (pick_any) begin
            req_ready[pick_grant] <= 1'b1;
            op.we                 <= bus.req_we_in[pick_grant];
            op.addr               <= pick_addr;
            op.data               <= pick_data;
            op.grant              <= pick_grant;
            state                 <= pick_addr_ok ? S_ISSUE : S_ERR;
          end
        end

        S_ISSUE: begin
          rd_en <= ~op.we;
          wr_en <= op.we;
          wdog  <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          // finished is tested first so it wins over a same-cycle timeout.
          if (bus.wr_finished_in) begin
            resp_valid[op.grant] <= 1'b1;
            if (!op.we) begin
              resp_data <= bus.wr_data_in;
            end
            last_grant <= op.grant;
            state      <= S_IDLE;
          end else if (wdog == WD_LAST) begin
            resp_valid[op.grant] <= 1'b1;
            resp_error           <= 1'b1;
            timeout_flag         <= 1'b1;
            last_grant           <= op.grant;
            state                <= S_IDLE;
          end else begin
            wdog <= wdog + WD_W'(1);
          end
        end

        S_ERR: begin
          resp_valid[op.grant] <= 1'b1;
          resp_error           <= 1'b1;
          last_grant           <= op.grant;
          state                <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // Wrapper address/data come straight from the op register, so they stay
  // stable for the whole WAIT and never follow the req_* inputs directly.
  assign bus.req_ready_out   = req_ready;
  assign bus.resp_valid_out  = resp_valid;
  assign bus.resp_data_out   = resp_data;
  assign bus.resp_error_out  = resp_error;
  assign bus.wr_addr_out     = op.addr;
  assign bus.wr_data_out     = op.data;
  assign bus.wr_read_en_out  = rd_en;
  assign bus.wr_write_en_out = wr_en;
  assign timeout_out         = timeout_flag;
  assign dbg_state           = state;

endmodule

// File: tb/tb_bram_wrapper_arbiter.sv
// Directed bench for bram_wrapper_arbiter with a behavioural bram_wrapper
// stand-in (fixed latency, optional hang to exercise the watchdog).
module tb_bram_wrapper_arbiter;
  import bram_wrapper_arbiter_pkg::*;

  localparam int ADDRS     = 24;
  localparam int WIDTH     = 256;
  localparam int NUM_REQ   = 2;
  localparam int TIMEOUT   = 8;
  localparam int ADDR_SIZE = 5;
  localparam int LAT       = 3;
  localparam int W         = WIDTH + 4;   // {care, resp_valid[1:0], err, data}

  localparam logic [WIDTH-1:0] D1 = {8{32'hBEAD_8888}};
  localparam logic [WIDTH-1:0] D3 = {8{32'h1212_7777}};

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  logic   timeout;
  state_t dbg_state;
  always #5 clk = ~clk;

  bram_wrapper_arbiter_if #(.ADDR_SIZE(ADDR_SIZE), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();

  bram_wrapper_arbiter #(
    .ADDRS(ADDRS), .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_in      (clk),
    .rst_n_in    (rst_n),
    .bus         (bus),
    .timeout_out (timeout),
    .dbg_state   (dbg_state)
  );

  // ---------------- wrapper stand-in ----------------
  function automatic logic [WIDTH-1:0] pat(input int i);
    return {8{32'hC0DE_0000 | 32'(i)}};
  endfunction

  logic [WIDTH-1:0] mem [ADDRS];
  logic             stub_busy;
  int               stub_cnt;
  logic             hang = 1'b0;

  // Wrapper reset is the inverse of rst_n, as at system level.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_busy          <= 1'b0;
      stub_cnt           <= 0;
      bus.wr_finished_in <= 1'b0;
      bus.wr_data_in     <= '0;
      for (int i = 0; i < ADDRS; i++) mem[i] <= pat(i);
    end else begin
      bus.wr_finished_in <= 1'b0;
      if (bus.wr_write_en_out) begin
        mem[bus.wr_addr_out] <= bus.wr_data_out;
        stub_busy <= 1'b1;
        stub_cnt  <= LAT;
      end else if (bus.wr_read_en_out) begin
        bus.wr_data_in <= mem[bus.wr_addr_out];
        stub_busy <= 1'b1;
        stub_cnt  <= LAT;
      end else if (stub_busy) begin
        stub_cnt <= stub_cnt - 1;
        if (stub_cnt == 1) begin
          stub_busy          <= 1'b0;
          bus.wr_finished_in <= ~hang;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_pulses = 0, wr_pulses = 0;
  int ready_cyc = 0, en_cyc = 0, fin_cyc = 0, resp_cyc = 0;
  int grant_log[$];

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_resp(input int r, input logic err, input logic care,
                             input logic [WIDTH-1:0] data);
    logic [1:0] oh;
    oh = 2'b01 << r;
    exp_q.push_back({care, oh, err, care ? data : {WIDTH{1'b0}}});
  endtask

  // ---------------- driver ----------------
  task automatic post(input int r, input logic we, input int addr, input logic [WIDTH-1:0] data);
    bus.req_valid_in[r] = 1'b1;
    bus.req_we_in[r]    = we;
    bus.req_addr_in[r*ADDR_SIZE +: ADDR_SIZE] = ADDR_SIZE'(addr);
    bus.req_data_in[r*WIDTH +: WIDTH]         = data;
  endtask

  // One cycle: sample at negedge, drop accepted valids, score responses.
  task automatic step();
    logic [W-1:0] e;
    logic [W-1:0] got;
    @(negedge clk);
    cyc++;
    if (bus.wr_read_en_out)  begin rd_pulses++; en_cyc = cyc; end
    if (bus.wr_write_en_out) begin wr_pulses++; en_cyc = cyc; end
    if (bus.wr_finished_in) fin_cyc = cyc;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (bus.req_ready_out[r]) begin
        ready_cyc = cyc;
        grant_log.push_back(r);
        bus.req_valid_in[r] = 1'b0;
      end
    end
    if (bus.resp_valid_out != '0) begin
      resp_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_resp", W'(bus.resp_valid_out), '0);
      end else begin
        e   = exp_q.pop_front();
        got = {e[W-1], bus.resp_valid_out, bus.resp_error_out,
               e[W-1] ? bus.resp_data_out : {WIDTH{1'b0}}};
        check("resp", got, e);
      end
    end else if (bus.resp_error_out) begin
      check("err_without_valid", W'(bus.resp_error_out), '0);
    end
  endtask

  task automatic run_until_idle(input string tag);
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0 && bus.req_valid_in == '0 && dbg_state == S_IDLE) return;
      step();
    end
    check({tag, "_budget"}, 1, 0);
  endtask

  function automatic int order2();
    return (grant_log.size() == 2) ? grant_log[0] * 10 + grant_log[1] : 99;
  endfunction

  // ---------------- directed tests ----------------
  int rd0, wr0, done;

  initial begin
    bus.req_valid_in = '0;
    bus.req_we_in    = '0;
    bus.req_addr_in  = '0;
    bus.req_data_in  = '0;
    repeat (3) step();
    check("rst_ready", W'(bus.req_ready_out), '0);
    check("rst_resp_valid", W'(bus.resp_valid_out), '0);
    check("rst_enables", W'({bus.wr_read_en_out, bus.wr_write_en_out, timeout}), '0);
    check("rst_state", W'(dbg_state), W'(S_IDLE));
    rst_n = 1'b1;
    step();

    // 1: write then read back through requester 0
    rd0 = rd_pulses; wr0 = wr_pulses;
    post(0, 1'b1, 0, D1);
    expect_resp(0, 1'b0, 1'b0, '0);
    run_until_idle("t1_write");
    check("t1_wr_pulses", W'(wr_pulses - wr0), 1);
    check("t1_rd_pulses", W'(rd_pulses - rd0), 0);
    check("t1_accept_to_enable", W'(en_cyc - ready_cyc), 1);
    check("t1_finish_to_resp", W'(resp_cyc - fin_cyc), 1);
    post(0, 1'b0, 0, '0);
    expect_resp(0, 1'b0, 1'b1, D1);
    run_until_idle("t1_read");

    // 2: fairness; last served decides who goes first
    post(1, 1'b0, 7, '0);
    expect_resp(1, 1'b0, 1'b1, pat(7));
    run_until_idle("t2_pre1");
    grant_log.delete();
    post(0, 1'b0, 3, '0);
    post(1, 1'b0, 5, '0);
    expect_resp(0, 1'b0, 1'b1, pat(3));
    expect_resp(1, 1'b0, 1'b1, pat(5));
    run_until_idle("t2_round1");
    check("t2_order_01", W'(order2()), 1);
    post(0, 1'b0, 8, '0);
    expect_resp(0, 1'b0, 1'b1, pat(8));
    run_until_idle("t2_pre0");
    grant_log.delete();
    post(0, 1'b0, 10, '0);
    post(1, 1'b0, 11, '0);
    expect_resp(1, 1'b0, 1'b1, pat(11));
    expect_resp(0, 1'b0, 1'b1, pat(10));
    run_until_idle("t2_round2");
    check("t2_order_10", W'(order2()), 10);

    // 3: write by req1 ordered before read of the same word by req0
    grant_log.delete();
    post(1, 1'b1, 12, D3);
    post(0, 1'b0, 12, '0);
    expect_resp(1, 1'b0, 1'b0, '0);
    expect_resp(0, 1'b0, 1'b1, D3);
    run_until_idle("t3");
    check("t3_order_10", W'(order2()), 10);

    // 4: out-of-range address
    rd0 = rd_pulses; wr0 = wr_pulses;
    post(0, 1'b0, 24, '0);
    expect_resp(0, 1'b1, 1'b0, '0);
    run_until_idle("t4");
    check("t4_ready_to_err", W'(resp_cyc - ready_cyc), 1);
    check("t4_no_enable", W'((rd_pulses - rd0) + (wr_pulses - wr0)), 0);

    // 5: wrapper hang -> watchdog abort, then recovery
    hang = 1'b1;
    post(0, 1'b0, 2, '0);
    expect_resp(0, 1'b1, 1'b0, '0);
    run_until_idle("t5_hang");
    check("t5_enable_to_abort", W'(resp_cyc - en_cyc), TIMEOUT);
    check("t5_timeout_set", W'(timeout), 1);
    hang = 1'b0;
    post(1, 1'b0, 4, '0);
    expect_resp(1, 1'b0, 1'b1, pat(4));
    run_until_idle("t5_recover");
    check("t5_timeout_sticky", W'(timeout), 1);

    // 6: reset during WAIT drops the op and restores req0 priority
    post(0, 1'b0, 9, '0);
    expect_resp(0, 1'b0, 1'b1, pat(9));
    run_until_idle("t6_pre0");
    post(0, 1'b0, 6, '0);
    done = 0;
    for (int i = 0; i < 20 && done == 0; i++) begin
      step();
      if (dbg_state == S_WAIT) done = 1;
    end
    check("t6_reached_wait", W'(done), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_pulses", W'({bus.req_ready_out, bus.resp_valid_out, bus.resp_error_out,
                                  bus.wr_read_en_out, bus.wr_write_en_out, timeout}), '0);
    check("t6_async_addr", W'(bus.wr_addr_out), '0);
    check("t6_async_state", W'(dbg_state), W'(S_IDLE));
    repeat (3) step();
    rst_n = 1'b1;
    repeat (LAT + 3) step();
    grant_log.delete();
    post(0, 1'b0, 3, '0);
    post(1, 1'b0, 5, '0);
    expect_resp(0, 1'b0, 1'b1, pat(3));
    expect_resp(1, 1'b0, 1'b1, pat(5));
    run_until_idle("t6_after");
    check("t6_order_01", W'(order2()), 1);
    check("t6_queue_drained", W'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
